// File: rtl/muon_coincidence_trigger.sv
// N-channel scintillator coincidence trigger: per-channel sync, rising-edge and mask,
// then an M-of-N coincidence window driving a fixed-width trigger pulse and dead time.
module muon_coincidence_trigger #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int WIN_W       = 8,
    parameter int LEN_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           ch_in,
    input  logic [N_CH-1:0]           ch_mask,
    input  logic [WIN_W-1:0]          win_len,
    input  logic [$clog2(N_CH+1)-1:0] majority,
    input  logic [LEN_W-1:0]          pulse_len,
    input  logic [LEN_W-1:0]          dead_len,
    input  logic                      counter_clr,
    output logic                      trig_out,
    output logic [N_CH-1:0]           trig_hits,
    output logic [CNT_W-1:0]          trig_count,
    output logic                      busy
);
    localparam int MAJ_W = $clog2(N_CH+1);

    typedef enum logic [1:0] {IDLE, OPEN, FIRE, DEAD} state_t;

    function automatic logic [MAJ_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [MAJ_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CH; i++) c = c + MAJ_W'(v[i]);
        return c;
    endfunction

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  prev_q;
    logic [N_CH-1:0]  edge_q;
    state_t           state_q;
    logic [N_CH-1:0]  hits_q;
    logic [N_CH-1:0]  trig_hits_q;
    logic [WIN_W-1:0] win_tmr_q;
    logic [LEN_W-1:0] pulse_tmr_q;
    logic [LEN_W-1:0] dead_tmr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             trig_q;
    logic             busy_q;
    logic [MAJ_W-1:0] eff_maj;
    logic [N_CH-1:0]  cand_d;
    logic             fire_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= ch_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q & ch_mask;
        end
    end

    // Candidate pattern is the accumulated window plus this cycle's strobes.
    always_comb begin
        eff_maj = (majority == '0) ? MAJ_W'(1) : majority;
        cand_d  = (state_q == OPEN) ? (hits_q | edge_q) : edge_q;
        fire_d  = ((state_q == IDLE) || (state_q == OPEN)) && (popcount(cand_d) >= eff_maj);
        count_d = count_q;
        if (counter_clr) begin
            count_d = '0;
        end else if (fire_d && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hits_q      <= '0;
            trig_hits_q <= '0;
            win_tmr_q   <= '0;
            pulse_tmr_q <= '0;
            dead_tmr_q  <= '0;
            count_q     <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            count_q <= count_d;
            case (state_q)
                IDLE, OPEN: begin
                    if (fire_d) begin
                        state_q     <= FIRE;
                        busy_q      <= 1'b1;
                        trig_q      <= 1'b1;
                        trig_hits_q <= cand_d;
                        hits_q      <= '0;
                        pulse_tmr_q <= (pulse_len == '0) ? LEN_W'(1) : pulse_len;
                        dead_tmr_q  <= dead_len;
                    end else if (state_q == IDLE) begin
                        if ((edge_q != '0) && (win_len != '0)) begin
                            state_q   <= OPEN;
                            busy_q    <= 1'b1;
                            hits_q    <= edge_q;
                            win_tmr_q <= win_len;
                        end
                    end else if (win_tmr_q == WIN_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        hits_q  <= '0;
                    end else begin
                        hits_q    <= cand_d;
                        win_tmr_q <= win_tmr_q - WIN_W'(1);
                    end
                end
                FIRE: begin
                    if (pulse_tmr_q == LEN_W'(1)) begin
                        trig_q <= 1'b0;
                        if (dead_tmr_q != '0) begin
                            state_q <= DEAD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        pulse_tmr_q <= pulse_tmr_q - LEN_W'(1);
                    end
                end
                DEAD: begin
                    if (dead_tmr_q == LEN_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        dead_tmr_q <= dead_tmr_q - LEN_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    trig_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig_out   = trig_q;
    assign trig_hits  = trig_hits_q;
    assign trig_count = count_q;
    assign busy       = busy_q;
endmodule
